// File: rtl/mc_maindec.sv
// mc_maindec: multicycle Moore main controller for the MIPS core.
// Sequences each instruction over shared ALU/memory with a memory handshake, timeout and trap.
module mc_maindec #(
  parameter int CNT_W       = 32,
  parameter bit TRAP_HALT   = 1'b1,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             memwrite,
  output logic             regwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       aluop,
  output logic             branch,
  output logic             ne,
  output logic             half,
  output logic             b,
  output logic             lbu,
  output logic             oneZero,
  output logic             link,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal,
  output logic             bus_err
);

  // state  | meaning
  // FETCH  | read instruction, PC+4; waits on mem_ready
  // DECODE | latch op, precompute branch target
  // MEMADR | load/store effective address
  // MEMRD  | load data access
  // MEMWB  | load writeback (retire)
  // MEMWR  | store data access (retire on mem_ready)
  // EXEC   | R-type ALU operation
  // ALUWB  | R-type writeback (retire)
  // BRANCH | compare and conditional PC update (retire)
  // IMMEX  | immediate ALU operation
  // IMMWB  | immediate writeback (retire)
  // JUMP   | PC <- jump target (retire)
  // JAL    | PC <- jump target, link register written (retire)
  // TRAP   | parked until reset
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, IMMEX, IMMWB, JUMP, JAL, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LBU   = 6'b100100;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            state, next_state;
  logic [5:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait, timeout_hit, op_illegal;
  logic              mem_req_c, irwrite_c, pcwrite_c, memwrite_c, regwrite_c, instr_done_c;
  logic [2:0]        imm_aluop;
  logic              imm_onezero;

  assign mem_wait    = ((state == FETCH) || (state == MEMRD) || (state == MEMWR)) && !mem_ready;
  assign timeout_hit = (MEM_TIMEOUT > 0) && mem_wait && (wait_cnt == WAIT_LAST);

  assign imm_aluop   = (op_q == OP_ORI) ? 3'b011 : (op_q == OP_ANDI) ? 3'b100 : 3'b000;
  assign imm_onezero = (op_q == OP_ORI) || (op_q == OP_ANDI);

  // Write strobes are held low for as long as reset is asserted.
  assign mem_req    = mem_req_c    & reset_n;
  assign irwrite    = irwrite_c    & reset_n;
  assign pcwrite    = pcwrite_c    & reset_n;
  assign memwrite   = memwrite_c   & reset_n;
  assign regwrite   = regwrite_c   & reset_n;
  assign instr_done = instr_done_c & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= FETCH;
      op_q        <= '0;
      wait_cnt    <= '0;
      instr_count <= '0;
      illegal     <= 1'b0;
      bus_err     <= 1'b0;
    end else begin
      state <= next_state;
      if (state == DECODE) op_q <= op;
      if ((MEM_TIMEOUT > 0) && mem_wait && !timeout_hit) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                                               wait_cnt <= '0;
      if (instr_done_c) instr_count <= instr_count + CNT_W'(1);
      if (op_illegal)   illegal <= 1'b1;
      if (timeout_hit)  bus_err <= 1'b1;
    end
  end

  always_comb begin
    next_state   = state;
    mem_req_c    = 1'b0;
    irwrite_c    = 1'b0;
    pcwrite_c    = 1'b0;
    memwrite_c   = 1'b0;
    regwrite_c   = 1'b0;
    instr_done_c = 1'b0;
    op_illegal   = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 3'b000;
    branch       = 1'b0;
    ne           = 1'b0;
    half         = 1'b0;
    b            = 1'b0;
    lbu          = 1'b0;
    oneZero      = 1'b0;
    link         = 1'b0;
    case (state)
      FETCH: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        if (mem_ready) begin
          irwrite_c  = 1'b1;
          pcwrite_c  = 1'b1;
          next_state = DECODE;
        end else if (timeout_hit) begin
          if (TRAP_HALT) next_state = TRAP;
          else           next_state = FETCH;
        end
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_RTYPE:                             next_state = EXEC;
          OP_LW, OP_LH, OP_LB, OP_LBU, OP_SW:   next_state = MEMADR;
          OP_BEQ, OP_BNE:                       next_state = BRANCH;
          OP_ADDI, OP_ORI, OP_ANDI:             next_state = IMMEX;
          OP_J:                                 next_state = JUMP;
          OP_JAL:                               next_state = JAL;
          default: begin
            op_illegal = 1'b1;
            if (TRAP_HALT) next_state = TRAP;
            else           next_state = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (op_q == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        if (mem_ready) next_state = MEMWB;
        else if (timeout_hit) begin
          if (TRAP_HALT) next_state = TRAP;
          else           next_state = FETCH;
        end
      end
      MEMWR: begin
        mem_req_c  = 1'b1;
        iord       = 1'b1;
        memwrite_c = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          next_state   = FETCH;
        end else if (timeout_hit) begin
          if (TRAP_HALT) next_state = TRAP;
          else           next_state = FETCH;
        end
      end
      MEMWB: begin
        regwrite_c   = 1'b1;
        memtoreg     = 1'b1;
        half         = (op_q == OP_LH) || (op_q == OP_LB);
        b            = (op_q == OP_LB);
        lbu          = (op_q == OP_LBU);
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      EXEC: begin
        alusrca    = 1'b1;
        aluop      = 3'b010;
        next_state = ALUWB;
      end
      ALUWB: begin
        regwrite_c   = 1'b1;
        regdst       = 1'b1;
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      BRANCH: begin
        alusrca      = 1'b1;
        aluop        = 3'b001;
        branch       = 1'b1;
        pcsrc        = 2'b01;
        ne           = (op_q == OP_BNE);
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        aluop      = imm_aluop;
        oneZero    = imm_onezero;
        next_state = IMMWB;
      end
      IMMWB: begin
        regwrite_c   = 1'b1;
        aluop        = imm_aluop;
        oneZero      = imm_onezero;
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      JUMP: begin
        pcsrc        = 2'b10;
        pcwrite_c    = 1'b1;
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      JAL: begin
        pcsrc        = 2'b10;
        pcwrite_c    = 1'b1;
        regwrite_c   = 1'b1;
        link         = 1'b1;
        instr_done_c = 1'b1;
        next_state   = FETCH;
      end
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: randomized instruction streams checked cycle by cycle against a micro-step model.
// Three controller configurations share the inputs; sel picks which one is being checked.
module tb_mc_maindec;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [5:0] op;
  logic       mem_ready;
  logic [1:0] sel;

  // control vector bit layout, shared by model and observation
  localparam logic [23:0] MREQ = 24'h800000, IORD = 24'h400000, IRW  = 24'h200000;
  localparam logic [23:0] PCW  = 24'h100000, MEMW = 24'h080000, REGW = 24'h040000;
  localparam logic [23:0] RDST = 24'h020000, MTOR = 24'h010000, ASA  = 24'h008000;
  localparam logic [23:0] BR   = 24'h000080, NE   = 24'h000040, HALF = 24'h000020;
  localparam logic [23:0] BB   = 24'h000010, LBU  = 24'h000008, OZ   = 24'h000004;
  localparam logic [23:0] LINK = 24'h000002, DONE = 24'h000001;

  wire [23:0] v0, v1, v2;
  wire [1:0]  f0, f1, f2;
  wire [3:0]  cnt0;
  wire [31:0] cnt1, cnt2;

  mc_maindec #(.CNT_W(4), .TRAP_HALT(1'b1), .MEM_TIMEOUT(4)) dut_h (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(v0[23]), .iord(v0[22]), .irwrite(v0[21]), .pcwrite(v0[20]), .memwrite(v0[19]),
    .regwrite(v0[18]), .regdst(v0[17]), .memtoreg(v0[16]), .alusrca(v0[15]),
    .alusrcb(v0[14:13]), .pcsrc(v0[12:11]), .aluop(v0[10:8]), .branch(v0[7]), .ne(v0[6]),
    .half(v0[5]), .b(v0[4]), .lbu(v0[3]), .oneZero(v0[2]), .link(v0[1]), .instr_done(v0[0]),
    .instr_count(cnt0), .illegal(f0[1]), .bus_err(f0[0]));

  mc_maindec #(.CNT_W(32), .TRAP_HALT(1'b0), .MEM_TIMEOUT(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(v1[23]), .iord(v1[22]), .irwrite(v1[21]), .pcwrite(v1[20]), .memwrite(v1[19]),
    .regwrite(v1[18]), .regdst(v1[17]), .memtoreg(v1[16]), .alusrca(v1[15]),
    .alusrcb(v1[14:13]), .pcsrc(v1[12:11]), .aluop(v1[10:8]), .branch(v1[7]), .ne(v1[6]),
    .half(v1[5]), .b(v1[4]), .lbu(v1[3]), .oneZero(v1[2]), .link(v1[1]), .instr_done(v1[0]),
    .instr_count(cnt1), .illegal(f1[1]), .bus_err(f1[0]));

  mc_maindec #(.CNT_W(32), .TRAP_HALT(1'b1), .MEM_TIMEOUT(0)) dut_d (
    .clk(clk), .reset_n(reset_n), .op(op), .mem_ready(mem_ready),
    .mem_req(v2[23]), .iord(v2[22]), .irwrite(v2[21]), .pcwrite(v2[20]), .memwrite(v2[19]),
    .regwrite(v2[18]), .regdst(v2[17]), .memtoreg(v2[16]), .alusrca(v2[15]),
    .alusrcb(v2[14:13]), .pcsrc(v2[12:11]), .aluop(v2[10:8]), .branch(v2[7]), .ne(v2[6]),
    .half(v2[5]), .b(v2[4]), .lbu(v2[3]), .oneZero(v2[2]), .link(v2[1]), .instr_done(v2[0]),
    .instr_count(cnt2), .illegal(f2[1]), .bus_err(f2[0]));

  logic [23:0] obs;
  logic [1:0]  obs_f;
  logic [31:0] obs_cnt;
  always_comb begin
    obs = v0; obs_f = f0; obs_cnt = {28'd0, cnt0};
    case (sel)
      2'd1: begin obs = v1; obs_f = f1; obs_cnt = cnt1; end
      2'd2: begin obs = v2; obs_f = f2; obs_cnt = cnt2; end
      default: ;
    endcase
  end

  int to_p [3] = '{4, 3, 0};
  bit th_p [3] = '{1'b1, 1'b0, 1'b1};
  int cw_p [3] = '{4, 32, 32};
  logic [5:0] legal [13] = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h24, 6'h2b, 6'h04,
                             6'h05, 6'h08, 6'h0d, 6'h0c, 6'h02, 6'h03};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed { logic [23:0] exp; logic rdy; logic [5:0] opv; } step_t;
  step_t       q[$];
  int unsigned exp_cnt;
  bit          exp_ill, exp_bus, halted;

  function automatic logic [23:0] sb(input int v); return 24'(v) << 13; endfunction
  function automatic logic [23:0] ps(input int v); return 24'(v) << 11; endfunction
  function automatic logic [23:0] ao(input int v); return 24'(v) << 8;  endfunction

  function automatic bit is_legal(input logic [5:0] o);
    foreach (legal[i]) if (legal[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [23:0] e, input logic r, input logic [5:0] o);
    step_t s;
    s.exp = e; s.rdy = r; s.opv = o;
    q.push_back(s);
  endtask

  task automatic trap_steps();
    repeat (4) push(24'h0, 1'($urandom), 6'($urandom));
  endtask

  // One memory access: waits, then either a ready cycle or a timeout after the budget.
  task automatic mem_phase(input int waits, input logic [23:0] wv, input logic [23:0] rv,
                           output bit ok);
    int to;
    to = to_p[sel];
    if (to > 0 && waits >= to) begin
      repeat (to) push(wv, 1'b0, 6'($urandom));
      exp_bus = 1'b1;
      if (th_p[sel]) begin halted = 1'b1; trap_steps(); end
      ok = 1'b0;
    end else begin
      repeat (waits) push(wv, 1'b0, 6'($urandom));
      push(rv, 1'b1, 6'($urandom));
      ok = 1'b1;
    end
  endtask

  task automatic build(input logic [5:0] o, input int fw, input int mw);
    bit ok;
    logic [23:0] x;
    mem_phase(fw, MREQ | sb(1), MREQ | IRW | PCW | sb(1), ok);
    if (!ok) return;
    push(sb(3), 1'($urandom), o);
    case (o)
      6'h00: begin push(ASA | ao(2), 1'($urandom), 6'($urandom));
                   push(REGW | RDST | DONE, 1'($urandom), 6'($urandom)); exp_cnt++; end
      6'h23, 6'h21, 6'h20, 6'h24: begin
        push(ASA | sb(2), 1'($urandom), 6'($urandom));
        mem_phase(mw, MREQ | IORD, MREQ | IORD, ok);
        if (ok) begin
          x = (o == 6'h21) ? HALF : (o == 6'h20) ? (HALF | BB) : (o == 6'h24) ? LBU : 24'h0;
          push(REGW | MTOR | x | DONE, 1'($urandom), 6'($urandom));
          exp_cnt++;
        end
      end
      6'h2b: begin
        push(ASA | sb(2), 1'($urandom), 6'($urandom));
        mem_phase(mw, MREQ | IORD | MEMW, MREQ | IORD | MEMW | DONE, ok);
        if (ok) exp_cnt++;
      end
      6'h04, 6'h05: begin
        push(ASA | ao(1) | BR | ps(1) | ((o == 6'h05) ? NE : 24'h0) | DONE, 1'($urandom), 6'($urandom));
        exp_cnt++;
      end
      6'h08, 6'h0d, 6'h0c: begin
        x = (o == 6'h0d) ? (ao(3) | OZ) : (o == 6'h0c) ? (ao(4) | OZ) : 24'h0;
        push(ASA | sb(2) | x, 1'($urandom), 6'($urandom));
        push(REGW | x | DONE, 1'($urandom), 6'($urandom));
        exp_cnt++;
      end
      6'h02: begin push(ps(2) | PCW | DONE, 1'($urandom), 6'($urandom)); exp_cnt++; end
      6'h03: begin push(ps(2) | PCW | REGW | LINK | DONE, 1'($urandom), 6'($urandom)); exp_cnt++; end
      default: begin
        exp_ill = 1'b1;
        if (th_p[sel]) begin halted = 1'b1; trap_steps(); end
      end
    endcase
  endtask

  // Each step is driven at a negedge, sampled 1ns later, and ends at the following negedge.
  task automatic run_n(input int n);
    step_t s;
    for (int i = 0; i < n && q.size() > 0; i++) begin
      s = q.pop_front();
      op = s.opv; mem_ready = s.rdy;
      #1;
      chk("ctl", 32'(obs), 32'(s.exp));
      @(negedge clk);
    end
  endtask

  task automatic instr(input logic [5:0] o, input int fw, input int mw);
    q.delete();
    build(o, fw, mw);
    run_n(q.size());
    #1;
    chk("count", obs_cnt, (cw_p[sel] == 4) ? (exp_cnt & 32'hF) : exp_cnt);
    chk("illegal", 32'(obs_f[1]), 32'(exp_ill));
    chk("bus_err", 32'(obs_f[0]), 32'(exp_bus));
  endtask

  task automatic do_reset();
    reset_n = 1'b0; mem_ready = 1'b1; op = 6'($urandom);
    #1;
    chk("rst_strobes", 32'(obs & (MREQ | IRW | PCW | MEMW | REGW | DONE)), 32'h0);
    chk("rst_count", obs_cnt, 32'h0);
    chk("rst_flags", 32'(obs_f), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    exp_cnt = 0; exp_ill = 1'b0; exp_bus = 1'b0; halted = 1'b0;
  endtask

  task automatic rand_instrs(input int n, input int maxw, input bit allow_ill);
    logic [5:0] o;
    for (int i = 0; i < n; i++) begin
      if (allow_ill && $urandom_range(0, 7) == 0) begin
        o = 6'($urandom);
        while (is_legal(o)) o = 6'($urandom);
      end else begin
        o = legal[$urandom_range(0, 12)];
      end
      instr(o, $urandom_range(0, maxw), $urandom_range(0, maxw));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; op = 6'h00; mem_ready = 1'b0; sel = 2'd0;
    exp_cnt = 0; exp_ill = 1'b0; exp_bus = 1'b0; halted = 1'b0;
    @(negedge clk);

    do_reset();
    instr(6'h00, 0, 0);
    instr(6'h20, 0, 3);
    instr(6'h05, 0, 0);
    instr(6'h0d, 1, 0);

    do_reset();
    repeat (16) instr(6'h03, 0, 0);

    rand_instrs(40, 3, 1'b0);

    // abandon a load in MEMRD, then make sure the next instruction starts clean
    q.delete();
    build(6'h23, 0, 2);
    run_n(3);
    q.delete();
    do_reset();
    instr(6'h00, 0, 0);

    instr(6'h2b, 0, 3);
    instr(6'h23, 3, 3);
    instr(6'h00, 4, 0);
    do_reset();
    instr(6'h23, 0, 5);
    do_reset();
    instr(6'h3f, 0, 0);
    do_reset();

    sel = 2'd1;
    do_reset();
    instr(6'h3f, 0, 0);
    instr(6'h00, 3, 0);
    instr(6'h2b, 0, 3);
    instr(6'h00, 0, 0);
    rand_instrs(60, 4, 1'b1);

    sel = 2'd2;
    do_reset();
    instr(6'h23, 7, 7);
    rand_instrs(40, 7, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main controller for the MIPS core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback steps, so ALU and memory are shared across cycles. Supports the full single-cycle opcode set (R-type, LW, LH, LB, LBU, SW, BEQ, BNE, ADDI, ORI, ANDI, J, JAL) and adds a variable-latency memory handshake, a memory timeout, an illegal-opcode trap and a retired-instruction counter. Sits between the instruction register (op source) and the datapath/ALU decoder.

## Interface
- CNT_W, 32, width of retired-instruction counter
- TRAP_HALT, 1, 1: illegal opcode or timeout parks FSM in TRAP; 0: log flag, return to FETCH
- MEM_TIMEOUT, 0, max wait cycles on mem_ready per access; 0 disables timeout
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- op  in  6  opcode from instruction register; sampled only in DECODE
- mem_ready  in  1  memory completes current access this cycle
- mem_req  out  1  memory access request (held until mem_ready)
- iord, irwrite, pcwrite, memwrite, regwrite, regdst, memtoreg, alusrca  out  1 each  datapath controls
- alusrcb  out  2  00 reg, 01 const 4, 10 sign/zero imm, 11 imm<<2
- pcsrc  out  2  00 ALU result, 01 ALU out register, 10 jump target
- aluop  out  3  000 add, 001 sub, 010 R-type funct, 011 or, 100 and
- branch, ne, half, b, lbu, oneZero, link  out  1 each  qualifiers as in single-cycle decoder
- instr_done  out  1  one-cycle pulse on instruction retirement
- instr_count  out  CNT_W  retired instructions, wraps
- illegal, bus_err  out  1 each  sticky error flags

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEX, IMMWB, JUMP, JAL, TRAP.
- Unlisted outputs are 0 in every state. op latched into op_q in DECODE; all later states use op_q.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=000, pcsrc=00; irwrite=pcwrite=1 only in the mem_ready cycle; on mem_ready -> DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=000. Next: 000000->EXEC; 100011/100001/100000/100100/101011->MEMADR; 000100/000101->BRANCH; 001000/001101/001100->IMMEX; 000010->JUMP; 000011->JAL; other -> TRAP path (illegal=1).
- MEMADR: alusrca=1, alusrcb=10, aluop=000; SW->MEMWR else MEMRD.
- MEMRD: mem_req=1, iord=1; on mem_ready -> MEMWB. MEMWR: mem_req=1, iord=1, memwrite=1; on mem_ready -> FETCH (retire).
- MEMWB: regwrite=1, memtoreg=1, regdst=0; half=1 for LH, half=1,b=1 for LB, lbu=1 for LBU -> FETCH (retire).
- EXEC: alusrca=1, alusrcb=00, aluop=010 -> ALUWB: regwrite=1, regdst=1 -> FETCH (retire).
- BRANCH: alusrca=1, alusrcb=00, aluop=001, branch=1, pcsrc=01, ne=1 for BNE -> FETCH (retire).
- IMMEX: alusrca=1, alusrcb=10; aluop 000 ADDI, 011 ORI (oneZero=1), 100 ANDI (oneZero=1) -> IMMWB: regwrite=1, regdst=0, aluop/oneZero held -> FETCH (retire).
- JUMP: pcsrc=10, pcwrite=1 -> FETCH (retire). JAL: pcsrc=10, pcwrite=1, regwrite=1, link=1 -> FETCH (retire).
- Timeout: wait counter clears on entry to FETCH/MEMRD/MEMWR; if MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT without mem_ready, bus_err=1, mem_req drops next cycle, go TRAP (TRAP_HALT=1) or FETCH without retire (TRAP_HALT=0).
- TRAP: all strobes 0; stays until reset when TRAP_HALT=1. With TRAP_HALT=0 illegal opcodes go DECODE->FETCH directly, no retire, no register/memory write.
- Retire: instr_done=1 for the cycle in a retiring state; instr_count increments at that edge, wraps 2^CNT_W-1 -> 0.

## Timing
- Reset (reset_n=0): state=FETCH, instr_count=0, illegal=bus_err=0, op_q=0, wait counter=0; mem_req, irwrite, pcwrite, memwrite, regwrite, instr_done forced 0 while asserted; mid-instruction reset abandons it with no retire.
- First cycle after release: FETCH, mem_req=1.
- Zero-wait memory (mem_ready always 1): R-type/ADDI/ORI/ANDI 4 cycles, LW/LH/LB/LBU 5, SW 4, BEQ/BNE 3, J/JAL 3.
- Each wait cycle adds one cycle; mem_req and address controls stable while waiting.
- mem_ready outside FETCH/MEMRD/MEMWR ignored.

## Test plan
- Reset then R-type (op=000000), mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB; regwrite=regdst=1 in cycle 4; instr_count=1.
- LB with mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles, MEMWB has half=b=1, memtoreg=1; total 8 cycles.
- BNE -> BRANCH with aluop=001, ne=1, pcsrc=01; 3 cycles, instr_done once.
- op=111111, TRAP_HALT=1 -> illegal=1, FSM stuck in TRAP, no strobes, count unchanged; reset_n low clears all.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> bus_err=1 after 4 wait cycles, TRAP; with TRAP_HALT=0 returns to FETCH.
- CNT_W=4, 16 JAL instructions -> link=regwrite=pcwrite=1 each, instr_count wraps to 0.
